// File: rtl/line_frame_sequencer_if.sv
// Raster timing bundle between a frame controller and the line/frame sequencer.
// The controller (master) drives the enable/request inputs; the sequencer
// (slave) drives the pixel coordinates and the timing strobes.
interface line_frame_sequencer_if #(
    parameter int XW = 5,
    parameter int YW = 5
);
    logic          enb;
    logic          start;
    logic          continuous;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          pix_valid;
    logic          new_line;
    logic          end_frame;
    logic          busy;

    modport master (
        output enb, start, continuous,
        input  pix_x, pix_y, pix_valid, new_line, end_frame, busy
    );

    modport slave (
        input  enb, start, continuous,
        output pix_x, pix_y, pix_valid, new_line, end_frame, busy
    );
endinterface

// File: rtl/line_frame_sequencer.sv
// Raster timing source: walks PIX_PER_LINE active pixels plus HBLANK blank
// cycles per line for LINES_PER_FRAME lines, then VBLANK blank cycles.
// Every output is a flop loaded from the next-state logic, so downstream
// pattern generators see glitch-free coordinates and strobes.
module line_frame_sequencer #(
    parameter int PIX_PER_LINE    = 32,
    parameter int HBLANK          = 4,
    parameter int LINES_PER_FRAME = 24,
    parameter int VBLANK          = 2,
    parameter int XW              = 5,
    parameter int YW              = 5
) (
    input logic                   clk,
    input logic                   rst_n,
    line_frame_sequencer_if.slave bus
);

    localparam int HW = (HBLANK > 1) ? $clog2(HBLANK) : 1;
    localparam int VW = (VBLANK > 1) ? $clog2(VBLANK) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(PIX_PER_LINE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(LINES_PER_FRAME - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HBLANK - 1);
    localparam logic [VW-1:0] V_LAST = VW'(VBLANK - 1);

    // Counter widths must hold every coordinate without wrapping.
    if (PIX_PER_LINE < 2 || PIX_PER_LINE > 2 ** XW) begin : g_bad_x
        $error("PIX_PER_LINE must be in 2..2**XW");
    end
    if (LINES_PER_FRAME < 2 || LINES_PER_FRAME > 2 ** YW) begin : g_bad_y
        $error("LINES_PER_FRAME must be in 2..2**YW");
    end
    if (HBLANK < 1 || VBLANK < 1) begin : g_bad_blank
        $error("HBLANK and VBLANK must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_HBLANK,
        S_VBLANK
    } state_e;

    state_e        state_q,     state_d;
    logic [XW-1:0] xcnt_q,      xcnt_d;
    logic [YW-1:0] ycnt_q,      ycnt_d;
    logic [HW-1:0] hcnt_q,      hcnt_d;
    logic [VW-1:0] vcnt_q,      vcnt_d;
    logic          pix_valid_q, pix_valid_d;
    logic          new_line_q,  new_line_d;
    logic          end_frame_q, end_frame_d;
    logic          busy_q,      busy_d;

    // Next-state, next-counter and next-output decode; enb low overrides everything.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        xcnt_d  = xcnt_q;
        ycnt_d  = ycnt_q;
        hcnt_d  = '0;
        vcnt_d  = '0;

        if (!bus.enb) begin
            state_d = S_IDLE;
            xcnt_d  = '0;
            ycnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d = S_ACTIVE;
                        xcnt_d  = '0;
                        ycnt_d  = '0;
                    end
                end
                S_ACTIVE: begin
                    if (xcnt_q == X_LAST) begin
                        state_d = S_HBLANK;
                        xcnt_d  = '0;
                    end else begin
                        xcnt_d = xcnt_q + 1'b1;
                    end
                end
                S_HBLANK: begin
                    if (hcnt_q == H_LAST) begin
                        if (ycnt_q < Y_LAST) begin
                            state_d = S_ACTIVE;
                            ycnt_d  = ycnt_q + 1'b1;
                        end else begin
                            state_d = S_VBLANK;
                            ycnt_d  = '0;
                        end
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end
                S_VBLANK: begin
                    if (vcnt_q == V_LAST) begin
                        if (bus.continuous) begin
                            state_d = S_ACTIVE;
                            xcnt_d  = '0;
                            ycnt_d  = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        vcnt_d = vcnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Strobes mark the final cycle of each blanking interval, looking at
        // where the counters will be next cycle so the outputs stay registered.
        pix_valid_d = (state_d == S_ACTIVE);
        busy_d      = (state_d != S_IDLE);
        new_line_d  = (state_d == S_HBLANK) && (hcnt_d == H_LAST);
        end_frame_d = (state_d == S_VBLANK) && (vcnt_d == V_LAST);
    end

    // State, counter and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the reset is in the sensitivity list so outputs clear the
        // moment rst_n falls, not at the next clock edge.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            xcnt_q      <= '0;
            ycnt_q      <= '0;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            pix_valid_q <= 1'b0;
            new_line_q  <= 1'b0;
            end_frame_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q     <= state_d;
            xcnt_q      <= xcnt_d;
            ycnt_q      <= ycnt_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            pix_valid_q <= pix_valid_d;
            new_line_q  <= new_line_d;
            end_frame_q <= end_frame_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.pix_x     = xcnt_q;
    assign bus.pix_y     = ycnt_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.new_line  = new_line_q;
    assign bus.end_frame = end_frame_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_line_frame_sequencer.sv
// Scoreboard bench for line_frame_sequencer. The stimulus process pushes the
// expected outputs for each cycle (from a closed-form raster position model);
// a separate monitor pops and compares on the falling clock edge.
module tb_line_frame_sequencer;

    localparam int PPL   = 32;
    localparam int HB    = 4;
    localparam int LPF   = 24;
    localparam int VB    = 2;
    localparam int XW    = 5;
    localparam int YW    = 5;
    localparam int LINE  = PPL + HB;
    localparam int FRAME = LPF * LINE + VB;   // 866

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          valid;
        logic          new_line;
        logic          end_frame;
        logic          busy;
    } out_t;

    typedef struct {
        string tag;
        int    cyc;
        out_t  exp;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    line_frame_sequencer_if #(.XW(XW), .YW(YW)) bus ();

    line_frame_sequencer #(
        .PIX_PER_LINE   (PPL),
        .HBLANK         (HB),
        .LINES_PER_FRAME(LPF),
        .VBLANK         (VB),
        .XW             (XW),
        .YW             (YW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    exp_t  sb_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    t           = 0;     // 0 = idle, 1..FRAME = position within frame
    int    cyc         = 0;
    string cur_tag     = "";

    // Expected outputs for frame position tt, derived from cycle arithmetic.
    function automatic out_t model(int tt);
        out_t o;
        int   u;
        int   ln;
        int   col;
        o = '0;
        if (tt <= 0) return o;
        u      = tt - 1;
        o.busy = 1'b1;
        if (u < LPF * LINE) begin
            ln  = u / LINE;
            col = u % LINE;
            o.y = YW'(ln);
            if (col < PPL) begin
                o.valid = 1'b1;
                o.x     = XW'(col);
            end else begin
                o.new_line = (col == LINE - 1);
            end
        end else begin
            o.end_frame = ((u - LPF * LINE) == VB - 1);
        end
        return o;
    endfunction

    function automatic int next_t(int tt, logic enb, logic start, logic cont);
        if (!enb)        return 0;
        if (tt == 0)     return start ? 1 : 0;
        if (tt == FRAME) return cont ? 1 : 0;
        return tt + 1;
    endfunction

    task automatic check(string name, int c, out_t act, out_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got x=%0d y=%0d valid=%b nl=%b ef=%b busy=%b, want x=%0d y=%0d valid=%b nl=%b ef=%b busy=%b",
                     name, c, act.x, act.y, act.valid, act.new_line, act.end_frame, act.busy,
                     exp.x, exp.y, exp.valid, exp.new_line, exp.end_frame, exp.busy);
        end
    endtask

    // One clock cycle: queue this cycle's expectation, drive inputs, advance.
    task automatic step(logic rst_v, logic enb, logic start, logic cont);
        exp_t e;
        if (!rst_v) begin
            rst_n = 1'b0;
            t     = 0;
        end else begin
            rst_n = 1'b1;
        end
        e.tag = cur_tag;
        e.cyc = cyc;
        e.exp = model(t);
        sb_q.push_back(e);
        bus.enb        = enb;
        bus.start      = start;
        bus.continuous = cont;
        @(posedge clk);
        #1;
        t = rst_v ? next_t(t, enb, start, cont) : 0;
        cyc++;
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        out_t act;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = {bus.pix_x, bus.pix_y, bus.pix_valid, bus.new_line, bus.end_frame, bus.busy};
            check(e.tag, e.cyc, act, e.exp);
        end
    end

    initial begin
        bus.enb        = 1'b0;
        bus.start      = 1'b0;
        bus.continuous = 1'b0;
        rst_n          = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with random inputs, then released with start low.
        cur_tag = "reset_hold"; cyc = 0;
        for (int k = 0; k < 6; k++)
            step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
        cur_tag = "reset_release"; cyc = 0;
        for (int k = 0; k < 4; k++)
            step(1'b1, 1'b1, 1'b0, 1'b0);

        // Single frame, continuous low.
        cur_tag = "single_frame"; cyc = 0;
        for (int k = 0; k <= FRAME + 4; k++)
            step(1'b1, 1'b1, k == 0, 1'b0);

        // Two back-to-back frames via continuous; drop it during the second.
        cur_tag = "continuous"; cyc = 0;
        for (int k = 0; k <= 2 * FRAME + 3; k++)
            step(1'b1, 1'b1, k == 0, k < FRAME + 10);

        // Abort in line 2; start while disabled is ignored.
        cur_tag = "enb_abort"; cyc = 0;
        for (int k = 0; k <= 110; k++)
            step(1'b1, !(k >= 100 && k <= 105), (k == 0) || (k == 103), 1'b0);

        // Async reset mid-frame, then a fresh frame.
        cur_tag = "async_reset"; cyc = 0;
        for (int k = 0; k <= 505 + FRAME + 3; k++)
            step(!(k == 500 || k == 501), 1'b1, (k == 0) || (k == 505), 1'b0);

        // start re-asserted while busy has no effect.
        cur_tag = "start_ignored"; cyc = 0;
        for (int k = 0; k <= FRAME + 4; k++)
            step(1'b1, 1'b1, (k == 0) || (k == 10) || (k == 865), 1'b0);

        // Let the monitor drain the scoreboard, with a bounded wait.
        for (int w = 0; w < 4 && sb_q.size() > 0; w++)
            @(negedge clk);
        #1;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
